// File: rtl/enc8b10b_multilane.sv
// Multi-lane 8b/10b encoder: LANES bytes per beat, running disparity chained
// lane 0 -> lane LANES-1, one output register stage with valid/ready.
module enc8b10b_multilane #(
  parameter int unsigned LANES   = 2,
  parameter bit          RD_INIT = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [8*LANES-1:0]    data_in,
  input  logic [LANES-1:0]      k_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [10*LANES-1:0]   data_out,
  output logic [LANES-1:0]      k_err,
  output logic                  rd
);

  localparam int unsigned W_BYTE = 8;
  localparam int unsigned W_SYM  = 10;

  // 5b/6b data code at RD- (abcdei)
  function automatic logic [5:0] code6_neg(input logic [4:0] x);
    logic [5:0] c;
    case (x)
      5'd0:  c = 6'b100111;  5'd1:  c = 6'b011101;
      5'd2:  c = 6'b101101;  5'd3:  c = 6'b110001;
      5'd4:  c = 6'b110101;  5'd5:  c = 6'b101001;
      5'd6:  c = 6'b011001;  5'd7:  c = 6'b111000;
      5'd8:  c = 6'b111001;  5'd9:  c = 6'b100101;
      5'd10: c = 6'b010101;  5'd11: c = 6'b110100;
      5'd12: c = 6'b001101;  5'd13: c = 6'b101100;
      5'd14: c = 6'b011100;  5'd15: c = 6'b010111;
      5'd16: c = 6'b011011;  5'd17: c = 6'b100011;
      5'd18: c = 6'b010011;  5'd19: c = 6'b110010;
      5'd20: c = 6'b001011;  5'd21: c = 6'b101010;
      5'd22: c = 6'b011010;  5'd23: c = 6'b111010;
      5'd24: c = 6'b110011;  5'd25: c = 6'b100110;
      5'd26: c = 6'b010110;  5'd27: c = 6'b110110;
      5'd28: c = 6'b001110;  5'd29: c = 6'b101110;
      5'd30: c = 6'b011110;  default: c = 6'b101011;
    endcase
    return c;
  endfunction

  // 3b/4b data code at RD- (fghj); a7 selects the alternate D.x.7 form
  function automatic logic [3:0] code4_neg(input logic [2:0] y, input logic a7);
    logic [3:0] c;
    case (y)
      3'd0:    c = 4'b1011;
      3'd1:    c = 4'b1001;
      3'd2:    c = 4'b0101;
      3'd3:    c = 4'b1100;
      3'd4:    c = 4'b1101;
      3'd5:    c = 4'b1010;
      3'd6:    c = 4'b0110;
      default: c = a7 ? 4'b0111 : 4'b1110;
    endcase
    return c;
  endfunction

  // K28.y 4b tail at RD- (the 6b head 001111 is common)
  function automatic logic [3:0] k28_tail(input logic [2:0] y);
    logic [3:0] c;
    case (y)
      3'd0:    c = 4'b0100;
      3'd1:    c = 4'b1001;
      3'd2:    c = 4'b0101;
      3'd3:    c = 4'b0011;
      3'd4:    c = 4'b0010;
      3'd5:    c = 4'b1010;
      3'd6:    c = 4'b0110;
      default: c = 4'b1000;
    endcase
    return c;
  endfunction

  // Encode one lane: returns {unsupported_k, symbol[9:0]}
  function automatic logic [W_SYM:0] encode_lane(input logic [W_BYTE-1:0] b,
                                                  input logic k,
                                                  input logic rd_in);
    logic [4:0] x;
    logic [2:0] y;
    logic [5:0] c6;
    logic [3:0] c4;
    logic       bal6;
    logic       rd6;
    logic       a7;
    logic       k28;
    logic       k_x7;
    logic       k_ok;
    logic [W_SYM-1:0] sym;
    x    = b[4:0];
    y    = b[7:5];
    k28  = (x == 5'd28);
    k_x7 = (b == 8'hF7) || (b == 8'hFB) || (b == 8'hFD) || (b == 8'hFE);
    k_ok = k && (k28 || k_x7);
    c6   = code6_neg(x);
    bal6 = ($countones(c6) == 3);
    rd6  = rd_in ^ !bal6;
    a7   = (!rd6 && ((x == 5'd17) || (x == 5'd18) || (x == 5'd20))) ||
           ( rd6 && ((x == 5'd11) || (x == 5'd13) || (x == 5'd14)));
    c4   = code4_neg(y, a7);
    if (k_ok) begin
      // control codes are complemented wholesale at RD+
      if (k28) sym = {6'b001111, k28_tail(y)};
      else     sym = {c6, 4'b1000};
      if (rd_in) sym = ~sym;
    end else begin
      // D.7 is balanced yet still has a distinct RD+ form
      if (rd_in && (!bal6 || (x == 5'd7))) c6 = ~c6;
      if (rd6 && ((y == 3'd0) || (y == 3'd3) || (y == 3'd4) || (y == 3'd7))) c4 = ~c4;
      sym = {c6, c4};
    end
    return {k && !k_ok, sym};
  endfunction

  logic [10*LANES-1:0] sym_c;
  logic [LANES-1:0]    kerr_c;
  logic                rd_end_c;
  logic [W_SYM:0]      lane_enc;

  assign in_ready = !out_valid || out_ready;

  // Encode all lanes, walking the running disparity from lane 0 upward
  always_comb begin
    sym_c    = '0;
    kerr_c   = '0;
    rd_end_c = rd;
    lane_enc = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      lane_enc             = encode_lane(data_in[W_BYTE*i +: W_BYTE], k_in[i], rd_end_c);
      sym_c[W_SYM*i +: W_SYM] = lane_enc[W_SYM-1:0];
      kerr_c[i]            = lane_enc[W_SYM];
      if ($countones(lane_enc[W_SYM-1:0]) != 5) rd_end_c = !rd_end_c;
    end
  end

  // Output stage: load on accept, clear valid on drain, hold on stall
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      data_out  <= '0;
      k_err     <= '0;
      rd        <= RD_INIT;
    end else if (in_valid && in_ready) begin
      out_valid <= 1'b1;
      data_out  <= sym_c;
      k_err     <= kerr_c;
      rd        <= rd_end_c;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/enc8b10b_multilane.md
# enc8b10b_multilane

Parametrised, multi-lane 8b/10b line encoder with valid/ready handshakes, K-character support and running disparity chained across lanes. It converts LANES bytes per accepted beat into LANES 10-bit symbols using the standard IEEE 802.3 Clause 36 code tables. It sits between the framing logic and the serialiser.

## Interface
- LANES, 2: bytes (and symbols) per beat, range 1..8; lane 0 is first on the wire.
- RD_INIT, 0: running disparity after reset; 0 = RD-, 1 = RD+.
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- in_valid  in  1  input beat valid.
- in_ready  out  1  encoder can accept a beat.
- data_in  in  8*LANES  lane i byte at [8i+7:8i]; bits HGF EDCBA = [7:5] [4:0].
- k_in  in  LANES  bit i set = lane i byte is a control character.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the output beat.
- data_out  out  10*LANES  lane i symbol at [10i+9:10i]; a at bit 9 through j at bit 0; abcdei = [9:4], fghj = [3:0].
- k_err  out  LANES  lane i had k_in set with an unsupported control code; registered with data_out.
- rd  out  1  running disparity after the last lane of the most recently accepted beat; 1 = RD+.

## Operation
- Single output register stage. in_ready = !out_valid || out_ready, combinationally.
- Accept = in_valid && in_ready. On accept: data_out, k_err, out_valid <= 1, rd <= chained RD.
- When out_valid && out_ready && !in_valid, out_valid <= 0 and data_out holds its value.
- Disparity chain: lane 0 uses the registered rd. Lane i+1 uses lane i's ending RD. The new rd is lane LANES-1's ending RD.
- Ending RD of a lane: unchanged if the symbol has five ones; otherwise inverted. Symbols always have 4, 5 or 6 ones.
- Data codes: standard 5b/6b and 3b/4b tables, selected by current RD. The 4b sub-block uses the RD after the 6b sub-block.
- D.x.7 uses the alternate A7 code (0111 at RD-, 1000 at RD+) when:
  - RD- and x is 17, 18 or 20, or
  - RD+ and x is 11, 13 or 14.
  - Otherwise it uses P7 (1110 at RD- / 0001 at RD+).
- Control codes at RD-:
  - K28.0..K28.7: 001111 followed by 0100, 1001, 0101, 0011, 0010, 1010, 0110, 1000.
  - K23.7 = 111010 1000; K27.7 = 110110 1000; K29.7 = 101110 1000; K30.7 = 011110 1000.
  - At RD+, each control code is the bitwise complement of its RD- code.
- Unsupported K (k_in=1 with any other byte): the lane is encoded as the data byte, its k_err bit is set, and the disparity chain proceeds normally.
- No state changes occur without an accept; rd holds through stalls.

## Timing
- Latency: 1 cycle from accept to out_valid/data_out.
- Throughput: 1 beat per cycle while out_ready stays high.
- Reset (async assert, sync release):
  - out_valid = 0.
  - data_out = 0.
  - k_err = 0.
  - rd = RD_INIT.
  - in_ready = 1 after reset.
- Stall: out_valid && !out_ready → in_ready = 0; data_out, k_err and rd are held stable.
- Simultaneous drain and fill (out_ready && in_valid with out_valid = 1): the new beat replaces the old one in the same cycle, with no bubble.
- Reset mid-stream: the pending beat is dropped and rd returns to RD_INIT.

## Test plan
- LANES=1, RD_INIT=0, K28.5 (k=1, 0xBC) -> 0x0FA, rd=1. Next K28.5 -> 0x305, rd=0.
- LANES=1, RD-: D3.0 (0x03) -> 0x31B, rd=1. Next D3.0 -> 0x314, rd=0. D21.5 (0xB5) -> 0x2AA, rd unchanged.
- LANES=2, RD-: lanes {D0.0 0x00, K28.5} -> lane0 0x274, lane1 0x0FA, rd=1. This checks the chaining and the A7 case: D17.7 (0xF1) at RD- -> 100011 0111.
- Unsupported K: k=1 with 0x00 -> k_err=1, symbol equals D0.0 encoding.
- Backpressure:
  - Hold out_ready=0 for 5 cycles while in_valid=1 -> in_ready=0, outputs stable, rd stable.
  - Release -> one beat per cycle, none lost or duplicated.
- Assert rst during a stalled beat -> out_valid=0, data_out=0, rd=RD_INIT immediately. The first beat after reset is encoded from RD_INIT.
